// File: rtl/mem_write_checker_pkg.sv
// Shared types for the data-memory write checker: FSM states and fail codes.
package mem_write_checker_pkg;

    localparam int FC_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PASS = 2'd2,
        ST_FAIL = 2'd3
    } state_t;

    typedef enum logic [FC_W-1:0] {
        FC_NONE            = 3'd0,
        FC_DATA_MISMATCH   = 3'd1,
        FC_UNEXPECTED_ADDR = 3'd2,
        FC_TIMEOUT         = 3'd3,
        FC_DUPLICATE       = 3'd4,
        FC_ORDER           = 3'd5
    } fail_code_t;

endpackage

// File: rtl/mwc_match_unit.sv
// Combinational classifier: decides whether a snooped write matches the
// expected table and, if not, which kind of failure it represents.
module mwc_match_unit
    import mem_write_checker_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 8,
    parameter int N_EXP  = 4,
    localparam int IDX_W = (N_EXP > 1) ? $clog2(N_EXP) : 1,
    localparam int CNT_W = $clog2(N_EXP + 1)
) (
    input  logic [N_EXP-1:0][ADDR_W-1:0] tbl_addr,
    input  logic [N_EXP-1:0][DATA_W-1:0] tbl_data,
    input  logic [N_EXP-1:0]             matched,
    input  logic [CNT_W-1:0]             num_exp,
    input  logic                         ordered,
    input  logic [CNT_W-1:0]             match_cnt,
    input  logic [ADDR_W-1:0]            address,
    input  logic [DATA_W-1:0]            wdata,
    output logic                         hit,
    output logic [IDX_W-1:0]             hit_idx,
    output fail_code_t                   fail_kind
);

    logic             cur_a, cur_d, earlier, later;
    logic             unm_full, unm_addr, m_addr;
    logic [IDX_W-1:0] ord_idx, lo_idx;

    always_comb begin
        cur_a    = 1'b0;
        cur_d    = 1'b0;
        earlier  = 1'b0;
        later    = 1'b0;
        unm_full = 1'b0;
        unm_addr = 1'b0;
        m_addr   = 1'b0;
        ord_idx  = '0;
        lo_idx   = '0;
        for (int i = 0; i < N_EXP; i++) begin
            if (CNT_W'(i) == match_cnt) ord_idx = IDX_W'(i);
            if ((CNT_W'(i) < num_exp) && (tbl_addr[i] == address)) begin
                if (CNT_W'(i) == match_cnt) begin
                    cur_a = 1'b1;
                    cur_d = (tbl_data[i] == wdata);
                end
                if (CNT_W'(i) < match_cnt) earlier = 1'b1;
                if (CNT_W'(i) > match_cnt) later = 1'b1;
                if (matched[i]) m_addr = 1'b1;
                else            unm_addr = 1'b1;
            end
        end
        // Descending scan so the lowest qualifying index is the one kept.
        for (int i = N_EXP - 1; i >= 0; i--) begin
            if ((CNT_W'(i) < num_exp) && !matched[i] &&
                (tbl_addr[i] == address) && (tbl_data[i] == wdata)) begin
                unm_full = 1'b1;
                lo_idx   = IDX_W'(i);
            end
        end
    end

    always_comb begin
        hit       = 1'b0;
        hit_idx   = '0;
        fail_kind = FC_UNEXPECTED_ADDR;
        if (ordered) begin
            if (cur_a && cur_d) begin
                hit       = 1'b1;
                hit_idx   = ord_idx;
                fail_kind = FC_NONE;
            end else if (cur_a)   fail_kind = FC_DATA_MISMATCH;
            else if (earlier)     fail_kind = FC_DUPLICATE;
            else if (later)       fail_kind = FC_ORDER;
        end else begin
            if (unm_full) begin
                hit       = 1'b1;
                hit_idx   = lo_idx;
                fail_kind = FC_NONE;
            end else if (unm_addr) fail_kind = FC_DATA_MISMATCH;
            else if (m_addr)       fail_kind = FC_DUPLICATE;
        end
    end

endmodule

// File: rtl/mem_write_checker.sv
// Snoops a data-memory write port and checks it against a programmed table
// of expected (address, data) writes, reporting sticky pass/fail.
module mem_write_checker
    import mem_write_checker_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 8,
    parameter int N_EXP  = 4,
    parameter int TMO_W  = 16,
    localparam int IDX_W = (N_EXP > 1) ? $clog2(N_EXP) : 1,
    localparam int CNT_W = $clog2(N_EXP + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wren,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] wdata,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [DATA_W-1:0] cfg_data,
    input  logic [CNT_W-1:0]  num_exp,
    input  logic              ordered,
    input  logic [ADDR_W-1:0] ign_lo,
    input  logic [ADDR_W-1:0] ign_hi,
    input  logic [TMO_W-1:0]  tmo_limit,
    input  logic              start,
    output logic              busy,
    output logic              pass,
    output logic              fail,
    output logic [FC_W-1:0]   fail_code,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data,
    output logic [CNT_W-1:0]  match_cnt,
    output state_t            state_dbg
);

    state_t                      state_q, state_d;
    logic [N_EXP-1:0][ADDR_W-1:0] tbl_addr_q;
    logic [N_EXP-1:0][DATA_W-1:0] tbl_data_q;
    logic [N_EXP-1:0]            matched_q;
    logic [CNT_W-1:0]            match_cnt_q, num_exp_q;
    logic                        ordered_q;
    logic [TMO_W-1:0]            tmo_cnt_q;
    fail_code_t                  fail_code_q;
    logic [ADDR_W-1:0]           fail_addr_q;
    logic [DATA_W-1:0]           fail_data_q;

    logic             hit, ign_hit, wr_act, do_match, do_fail, completes, tmo_hit, start_ok;
    logic [IDX_W-1:0] hit_idx;
    fail_code_t       fail_kind;

    mwc_match_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .N_EXP(N_EXP)) u_match (
        .tbl_addr (tbl_addr_q),
        .tbl_data (tbl_data_q),
        .matched  (matched_q),
        .num_exp  (num_exp_q),
        .ordered  (ordered_q),
        .match_cnt(match_cnt_q),
        .address  (address),
        .wdata    (wdata),
        .hit      (hit),
        .hit_idx  (hit_idx),
        .fail_kind(fail_kind)
    );

    assign ign_hit   = (ign_lo <= ign_hi) && (address >= ign_lo) && (address <= ign_hi);
    assign wr_act    = (state_q == ST_RUN) && wren && !ign_hit;
    assign do_match  = wr_act && hit;
    assign do_fail   = wr_act && !hit;
    assign completes = do_match && (CNT_W'(match_cnt_q + 1'b1) == num_exp_q);
    assign tmo_hit   = (tmo_limit != '0) && (tmo_cnt_q == TMO_W'(tmo_limit - 1'b1));
    assign start_ok  = start && (state_q != ST_RUN);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                // A deciding write takes precedence over a coinciding timeout.
                if (completes)    state_d = ST_PASS;
                else if (do_fail) state_d = ST_FAIL;
                else if (tmo_hit) state_d = ST_FAIL;
            end
            default: begin
                if (start) state_d = (num_exp == '0) ? ST_PASS : ST_RUN;
            end
        endcase
    end

    // Table contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (cfg_we && (state_q != ST_RUN)) begin
            tbl_addr_q[cfg_idx] <= cfg_addr;
            tbl_data_q[cfg_idx] <= cfg_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            matched_q   <= '0;
            match_cnt_q <= '0;
            num_exp_q   <= '0;
            ordered_q   <= 1'b0;
            tmo_cnt_q   <= '0;
            fail_code_q <= FC_NONE;
            fail_addr_q <= '0;
            fail_data_q <= '0;
        end else begin
            state_q <= state_d;
            if (start_ok) begin
                matched_q   <= '0;
                match_cnt_q <= '0;
                num_exp_q   <= num_exp;
                ordered_q   <= ordered;
                tmo_cnt_q   <= '0;
                fail_code_q <= FC_NONE;
                fail_addr_q <= '0;
                fail_data_q <= '0;
            end else if (state_q == ST_RUN) begin
                if (tmo_cnt_q != '1) tmo_cnt_q <= tmo_cnt_q + 1'b1;
                if (do_match) begin
                    matched_q[hit_idx] <= 1'b1;
                    match_cnt_q        <= match_cnt_q + 1'b1;
                end else if (do_fail) begin
                    fail_code_q <= fail_kind;
                    fail_addr_q <= address;
                    fail_data_q <= wdata;
                end
                if (!completes && !do_fail && tmo_hit) begin
                    fail_code_q <= FC_TIMEOUT;
                    fail_addr_q <= '0;
                    fail_data_q <= '0;
                end
            end
        end
    end

    assign busy      = (state_q == ST_RUN);
    assign pass      = (state_q == ST_PASS);
    assign fail      = (state_q == ST_FAIL);
    assign fail_code = fail_code_q;
    assign fail_addr = fail_addr_q;
    assign fail_data = fail_data_q;
    assign match_cnt = match_cnt_q;
    assign state_dbg = state_q;

endmodule
